rf_write_arbiter: RTL and testbench

Shares the single register-file write port between the pipeline writeback stage and a long-latency result source, such as a multi-cycle multiply/divide unit. Writeback always wins. Secondary results queue in a small FIFO and drain in idle writeback cycles. The block also provides per-read-port pending flags for decode hazard stalls, and a stall request that stops the secondary source from starving. It sits between writeback, the multi-cycle unit and `regfile`, and drives `regfile`'s `wen`/`waddr`/`wdata` directly.

---
 rtl/rf_write_arbiter_pkg.sv | 17 +
 rtl/rf_write_arbiter_if.sv | 48 ++++
 rtl/rf_write_arbiter_wq_fifo.sv | 105 ++++++++++
 rtl/rf_write_arbiter.sv | 132 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and state encoding for the register-file write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: RF_ASIZE/RF_DSIZE mirror ASIZE/DSIZE from define.v; starve_state_e is the starvation FSM encoding.
package rf_write_arbiter_pkg;

  // Register address / data widths shared with regfile (define.v ASIZE/DSIZE).
  localparam int RF_ASIZE = 5;
  localparam int RF_DSIZE = 32;

  // Starvation FSM: NORMAL lets writeback own the port, STARVED raises stall_req.
  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_STARVED = 1'b1
  } starve_state_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of writeback, secondary-result, decode-lookup and regfile-port signals.
// Latency: n/a (wiring only).
// Backpressure: s_valid/s_ready handshake on the secondary side; writeback has none.
// Modports: slave = arbiter view (consumes p_*/s_*/raddr*, drives s_ready/busy*/stall_req/rf_*),
//           master = environment view (the mirror image).
interface rf_write_arbiter_if
  import rf_write_arbiter_pkg::*;
#(
  parameter int ASIZE = RF_ASIZE,
  parameter int DSIZE = RF_DSIZE
);
  // Writeback (primary) write
  logic             p_wen;
  logic [ASIZE-1:0] p_waddr;
  logic [DSIZE-1:0] p_wdata;
  // Secondary (multi-cycle unit) result
  logic             s_valid;
  logic             s_ready;
  logic [ASIZE-1:0] s_waddr;
  logic [DSIZE-1:0] s_wdata;
  // Decode hazard lookup
  logic [ASIZE-1:0] raddr1;
  logic [ASIZE-1:0] raddr2;
  logic             busy1;
  logic             busy2;
  logic             stall_req;
  // Regfile write port
  logic             rf_wen;
  logic [ASIZE-1:0] rf_waddr;
  logic [DSIZE-1:0] rf_wdata;

  modport slave (
    input  p_wen, p_waddr, p_wdata,
    input  s_valid, s_waddr, s_wdata,
    input  raddr1, raddr2,
    output s_ready, busy1, busy2, stall_req,
    output rf_wen, rf_waddr, rf_wdata
  );

  modport master (
    output p_wen, p_waddr, p_wdata,
    output s_valid, s_waddr, s_wdata,
    output raddr1, raddr2,
    input  s_ready, busy1, busy2, stall_req,
    input  rf_wen, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/rf_write_arbiter_wq_fifo.sv
// rf_wq_fifo: secondary write queue with per-entry valid (squash) bits and address lookups.
// Latency: a pushed entry is visible at the head / in busy lookups from the next cycle.
// Backpressure: full_o reflects registered count only; caller must not push when full or pop when empty.
// Ports: push_* write at tail, pop_i advances head, sq_* clears matching entries,
//        raddr*_i/busy*_o hazard lookup, head_* describe the oldest slot, count_nxt_o is next occupancy.
module rf_wq_fifo #(
  parameter int ASIZE = 5,
  parameter int DSIZE = 32,
  parameter int DEPTH = 4,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [ASIZE-1:0] push_waddr_i,
  input  logic [DSIZE-1:0] push_wdata_i,
  input  logic             pop_i,
  input  logic             sq_en_i,
  input  logic [ASIZE-1:0] sq_waddr_i,
  input  logic [ASIZE-1:0] raddr1_i,
  input  logic [ASIZE-1:0] raddr2_i,
  output logic             full_o,
  output logic [CW-1:0]    count_nxt_o,
  output logic             head_occ_o,
  output logic             head_vld_o,
  output logic [ASIZE-1:0] head_waddr_o,
  output logic [DSIZE-1:0] head_wdata_o,
  output logic             busy1_o,
  output logic             busy2_o
);

  logic [ASIZE-1:0] waddr_q [DEPTH];
  logic [DSIZE-1:0] wdata_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  // Occupancy counts squashed slots too: they still hold a place until discarded at the head.
  assign full_o       = (count_q == CW'(DEPTH));
  assign head_occ_o   = (count_q != '0);
  assign head_vld_o   = vld_q[head_q];
  assign head_waddr_o = waddr_q[head_q];
  assign head_wdata_o = wdata_q[head_q];
  assign count_nxt_o  = count_d;

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_comb begin
    head_d  = head_q + PW'(pop_i);
    tail_d  = tail_q + PW'(push_i);
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A primary write is always younger than anything queued, so it kills queued
  // writes to the same register, including one arriving this very cycle.
  always_comb begin
    vld_d = vld_q;
    if (sq_en_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr_q[i] == sq_waddr_i) vld_d[i] = 1'b0;
      end
    end
    if (pop_i) vld_d[head_q] = 1'b0;
    if (push_i) vld_d[tail_q] = !(sq_en_i && (push_waddr_i == sq_waddr_i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: an entry's valid bit governs whether it is ever used.
  always_ff @(posedge clk) begin
    if (push_i) begin
      waddr_q[tail_q] <= push_waddr_i;
      wdata_q[tail_q] <= push_wdata_i;
    end
  end

  // Only registered valid entries count, so a same-cycle push never raises busy.
  always_comb begin
    busy1_o = 1'b0;
    busy2_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (waddr_q[i] == raddr1_i)) busy1_o = 1'b1;
      if (vld_q[i] && (waddr_q[i] == raddr2_i)) busy2_o = 1'b1;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the regfile write port: writeback wins, secondary results queue and drain in idle cycles.
// Latency: primary write combinational (0 cycles); secondary drains no earlier than the cycle after push.
// Backpressure: s_ready drops when the queue is full; stall_req asks for bubbles after STARVE_LIMIT blocked cycles.
// Ports: clk, rst (sync, active-high) plus wa (slave modport): p_* writeback in, s_* secondary handshake,
//        raddr*/busy* decode hazard lookup, stall_req, rf_* to regfile wen/waddr/wdata.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int ASIZE        = RF_ASIZE,
  parameter int DSIZE        = RF_DSIZE,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  rf_write_arbiter_if.slave  wa
);

  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int AGEW = $clog2(STARVE_LIMIT + 1);

  logic             push, pop, full;
  logic [CW-1:0]    count_nxt;
  logic             head_occ, head_vld;
  logic [ASIZE-1:0] head_waddr;
  logic [DSIZE-1:0] head_wdata;
  logic             busy1, busy2;

  logic             rf_wen;
  logic [ASIZE-1:0] rf_waddr;
  logic [DSIZE-1:0] rf_wdata;

  starve_state_e    state_q, state_d;
  logic [AGEW-1:0]  age_q, age_d;

  // s_ready looks at registered occupancy only; a same-cycle pop does not make room.
  assign wa.s_ready = !rst && !full;
  assign push       = wa.s_valid && wa.s_ready;

  rf_wq_fifo #(
    .ASIZE (ASIZE),
    .DSIZE (DSIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_waddr_i (wa.s_waddr),
    .push_wdata_i (wa.s_wdata),
    .pop_i        (pop),
    .sq_en_i      (wa.p_wen),
    .sq_waddr_i   (wa.p_waddr),
    .raddr1_i     (wa.raddr1),
    .raddr2_i     (wa.raddr2),
    .full_o       (full),
    .count_nxt_o  (count_nxt),
    .head_occ_o   (head_occ),
    .head_vld_o   (head_vld),
    .head_waddr_o (head_waddr),
    .head_wdata_o (head_wdata),
    .busy1_o      (busy1),
    .busy2_o      (busy2)
  );

  // Port mux. A squashed head is thrown away without touching the port, and
  // that discard proceeds even under a primary write since it costs nothing.
  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = wa.p_waddr;
    rf_wdata = wa.p_wdata;
    pop      = 1'b0;
    if (!rst) begin
      if (wa.p_wen) begin
        rf_wen = 1'b1;
        pop    = head_occ && !head_vld;
      end else if (head_occ) begin
        pop = 1'b1;
        if (head_vld) begin
          rf_wen   = 1'b1;
          rf_waddr = head_waddr;
          rf_wdata = head_wdata;
        end
      end
    end
  end

  assign wa.rf_wen   = rf_wen;
  assign wa.rf_waddr = rf_waddr;
  assign wa.rf_wdata = rf_wdata;
  assign wa.busy1    = !rst && busy1;
  assign wa.busy2    = !rst && busy2;
  assign wa.stall_req = !rst && (state_q == ST_STARVED);

  // Starvation tracking: age counts consecutive cycles a valid head loses to
  // writeback. Once starved, hold the stall until the queue fully empties so
  // the pipeline is not toggled per entry.
  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    case (state_q)
      ST_NORMAL: begin
        if (head_occ && head_vld && wa.p_wen) begin
          if (age_q == AGEW'(STARVE_LIMIT - 1)) state_d = ST_STARVED;
          else                                  age_d   = age_q + AGEW'(1);
        end else begin
          age_d = '0;
        end
      end
      ST_STARVED: begin
        if (count_nxt == '0) begin
          state_d = ST_NORMAL;
          age_d   = '0;
        end
      end
      default: begin
        state_d = ST_NORMAL;
        age_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_NORMAL;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomised scoreboard bench for rf_write_arbiter against a queue-based reference model.
// Latency: expectations are recorded per cycle and checked half a cycle later at the falling edge.
// Backpressure: the model applies the same s_ready rule; some phases honour stall_req by idling writeback.
module tb_rf_write_arbiter;

  localparam int ASIZE        = 5;
  localparam int DSIZE        = 32;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) bus ();

  rf_write_arbiter #(
    .ASIZE        (ASIZE),
    .DSIZE        (DSIZE),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wa  (bus.slave)
  );

  typedef struct {
    logic [ASIZE-1:0] addr;
    logic [DSIZE-1:0] data;
    bit               vld;
  } ent_t;

  typedef struct {
    int               cyc;
    bit               wen;
    logic [ASIZE-1:0] waddr;
    logic [DSIZE-1:0] wdata;
    bit               s_ready;
    bit               busy1;
    bit               busy2;
    bit               stall;
  } exp_t;

  ent_t mq[$];
  exp_t sbq[$];
  bit   starved;
  int   age;
  int   cyc;
  int   vectors;
  int   miscompares;

  function automatic void chk(string nm, int c, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, req);
    end
  endfunction

  // Monitor: one expectation record per driven cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("rf_wen", e.cyc, 32'(bus.rf_wen), 32'(e.wen));
      if (e.wen) begin
        chk("rf_waddr", e.cyc, 32'(bus.rf_waddr), 32'(e.waddr));
        chk("rf_wdata", e.cyc, bus.rf_wdata, e.wdata);
      end
      chk("s_ready", e.cyc, 32'(bus.s_ready), 32'(e.s_ready));
      chk("busy1", e.cyc, 32'(bus.busy1), 32'(e.busy1));
      chk("busy2", e.cyc, 32'(bus.busy2), 32'(e.busy2));
      chk("stall_req", e.cyc, 32'(bus.stall_req), 32'(e.stall));
    end
  end

  // Drive one cycle of inputs, record what the outputs must be, then advance the model.
  task automatic step(input bit r, input bit pw, input logic [ASIZE-1:0] pa, input logic [DSIZE-1:0] pd,
                      input bit sv, input logic [ASIZE-1:0] sa, input logic [DSIZE-1:0] sd,
                      input logic [ASIZE-1:0] r1, input logic [ASIZE-1:0] r2);
    exp_t e;
    bit   hv, pop, was_starved;
    @(posedge clk);
    #1;
    rst         = r;
    bus.p_wen   = pw;
    bus.p_waddr = pa;
    bus.p_wdata = pd;
    bus.s_valid = sv;
    bus.s_waddr = sa;
    bus.s_wdata = sd;
    bus.raddr1  = r1;
    bus.raddr2  = r2;
    cyc++;
    e = '{cyc: cyc, wen: 1'b0, waddr: '0, wdata: '0, s_ready: 1'b0, busy1: 1'b0, busy2: 1'b0, stall: 1'b0};
    if (r) begin
      mq.delete();
      starved = 1'b0;
      age     = 0;
    end else begin
      e.s_ready = (mq.size() < DEPTH);
      foreach (mq[i]) begin
        if (mq[i].vld && mq[i].addr == r1) e.busy1 = 1'b1;
        if (mq[i].vld && mq[i].addr == r2) e.busy2 = 1'b1;
      end
      e.stall = starved;
      hv  = (mq.size() > 0) && mq[0].vld;
      pop = 1'b0;
      if (pw) begin
        e.wen   = 1'b1;
        e.waddr = pa;
        e.wdata = pd;
        pop     = (mq.size() > 0) && !mq[0].vld;
      end else if (mq.size() > 0) begin
        pop = 1'b1;
        if (hv) begin
          e.wen   = 1'b1;
          e.waddr = mq[0].addr;
          e.wdata = mq[0].data;
        end
      end
      was_starved = starved;
      if (!starved) begin
        if (hv && pw) begin
          if (age + 1 >= STARVE_LIMIT) starved = 1'b1;
          else                         age++;
        end else begin
          age = 0;
        end
      end
      if (pop) void'(mq.pop_front());
      if (pw) foreach (mq[i]) if (mq[i].addr == pa) mq[i].vld = 1'b0;
      if (sv && e.s_ready) mq.push_back('{addr: sa, data: sd, vld: !(pw && sa == pa)});
      if (was_starved && mq.size() == 0) begin
        starved = 1'b0;
        age     = 0;
      end
    end
    sbq.push_back(e);
  endtask

  task automatic idle(input int n, input logic [ASIZE-1:0] r1);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0, r1, r1);
  endtask

  initial begin
    bit               pw, sv, r;
    logic [ASIZE-1:0] pa, sa, r1, r2;
    int               mode, len, wen_pct;
    rst = 1'b1;
    bus.p_wen = 1'b0; bus.p_waddr = '0; bus.p_wdata = '0;
    bus.s_valid = 1'b0; bus.s_waddr = '0; bus.s_wdata = '0;
    bus.raddr1 = '0; bus.raddr2 = '0;
    starved = 1'b0; age = 0; cyc = 0; vectors = 0; miscompares = 0;

    for (int i = 0; i < 3; i++) step(1, 0, '0, '0, 0, '0, '0, '0, '0);

    // Simple push with idle writeback, then drain the cycle after.
    step(0, 0, '0, '0, 1, 5'd5, 32'hAA, 5'd5, 5'd0);
    step(0, 0, '0, '0, 0, '0, '0, 5'd5, 5'd0);
    idle(2, 5'd5);

    // Fill under continuous writeback to r3, starve, then release.
    for (int i = 0; i < 4; i++) step(0, 1, 5'd3, 32'h300 + i, 1, 5'(10 + i), 32'h1000 + i, 5'd10, 5'd13);
    for (int i = 0; i < 10; i++) step(0, 1, 5'd3, 32'h310 + i, 1, 5'd20, 32'hDEAD, 5'd11, 5'd20);
    idle(6, 5'd12);

    // Queued r7 overwritten by a younger writeback.
    step(0, 1, 5'd3, 32'h1, 1, 5'd7, 32'h11, 5'd7, 5'd3);
    step(0, 1, 5'd7, 32'h22, 0, '0, '0, 5'd7, 5'd3);
    idle(2, 5'd7);

    // Same-cycle push and writeback to r9.
    step(0, 1, 5'd9, 32'h99, 1, 5'd9, 32'h55, 5'd9, 5'd9);
    idle(3, 5'd9);

    // Full queue, one pop with s_valid held: push lands only in the following cycle.
    for (int i = 0; i < 4; i++) step(0, 1, 5'd3, 32'h400 + i, 1, 5'(16 + i), 32'h2000 + i, 5'd16, 5'd21);
    step(0, 0, '0, '0, 1, 5'd21, 32'h2100, 5'd21, 5'd16);
    step(0, 0, '0, '0, 1, 5'd22, 32'h2200, 5'd21, 5'd22);
    idle(8, 5'd22);

    // Reset with three entries queued.
    for (int i = 0; i < 3; i++) step(0, 1, 5'd3, 32'h500 + i, 1, 5'(24 + i), 32'h3000 + i, 5'd24, 5'd26);
    step(1, 0, '0, '0, 0, '0, '0, 5'd24, 5'd26);
    idle(4, 5'd24);

    // Randomised phases over a small register range to provoke squashes and hazards.
    for (int ph = 0; ph < 40; ph++) begin
      mode = $urandom_range(0, 3);
      len  = $urandom_range(40, 120);
      case (mode)
        0:       wen_pct = 92;
        1:       wen_pct = 10;
        2:       wen_pct = 50;
        default: wen_pct = 85;
      endcase
      for (int i = 0; i < len; i++) begin
        pw = ($urandom_range(0, 99) < wen_pct);
        if (mode == 3 && starved) pw = 1'b0;
        sv = ($urandom_range(0, 99) < 60);
        r  = ($urandom_range(0, 299) == 0);
        pa = 5'($urandom_range(0, 7));
        sa = 5'($urandom_range(0, 7));
        r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        step(r, pw, pa, $urandom, sv, sa, $urandom, r1, r2);
      end
    end
    idle(10, '0);

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending records expected 0", sbq.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
